// File: rtl/hazard_seq_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and a
// multicycle-op sequencer. Define HAZARD_PERF_EN to add stall/flush counters.
module hazard_seq_ctrl #(
  parameter int MC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1_D,
  input  logic [4:0]  Rs2_D,
  input  logic [4:0]  Rs1_E,
  input  logic [4:0]  Rs2_E,
  input  logic [4:0]  RD_E,
  input  logic [4:0]  RD_M,
  input  logic [4:0]  RD_W,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        ResultSrcE,
  input  logic        PCSrcE,
  input  logic        mc_req_E,
  input  logic        mc_done,
  output logic [1:0]  ForwardA_E,
  output logic [1:0]  ForwardB_E,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        BubbleM,
  output logic        mc_start,
  output logic        mc_error,
`ifdef HAZARD_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic [1:0]  fsm_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(MC_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       load_use;

  // M stage has the newer value, so it wins over W.
  always_comb begin
    ForwardA_E = 2'b00;
    if (RegWriteM && (RD_M != 5'd0) && (RD_M == Rs1_E))      ForwardA_E = 2'b10;
    else if (RegWriteW && (RD_W != 5'd0) && (RD_W == Rs1_E)) ForwardA_E = 2'b01;
    ForwardB_E = 2'b00;
    if (RegWriteM && (RD_M != 5'd0) && (RD_M == Rs2_E))      ForwardB_E = 2'b10;
    else if (RegWriteW && (RD_W != 5'd0) && (RD_W == Rs2_E)) ForwardB_E = 2'b01;
  end

  assign load_use = ResultSrcE && (RD_E != 5'd0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Multicycle handshake: mc_start pulses once per accepted mc_req_E (only in
  // IDLE, never alongside a taken branch); mc_done is consumed only in WAIT.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    BubbleM  = 1'b0;
    mc_start = 1'b0;
    mc_error = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mc_req_E && !PCSrcE) begin
          mc_start = rst;
          StallF   = 1'b1;
          StallD   = 1'b1;
          StallE   = 1'b1;
          BubbleM  = 1'b1;
          cnt_d    = 8'd0;
          state_d  = S_WAIT;
        end else if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (load_use) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      S_WAIT: begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallE  = 1'b1;
        BubbleM = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        if (mc_done)                state_d = S_DONE;
        else if (cnt_q == CNT_LAST) state_d = S_ERR;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        StallF   = 1'b1;
        StallD   = 1'b1;
        StallE   = 1'b1;
        BubbleM  = 1'b1;
        mc_error = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign fsm_state_o = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 32'd0;
    end else begin
      if (StallF) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (FlushE) flush_count_q  <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_seq_ctrl.sv
// Self-checking bench for hazard_seq_ctrl: forwarding, load-use, branch flush,
// multicycle sequencing, timeout, reset abort and (with HAZARD_PERF_EN) counters.
module tb_hazard_seq_ctrl;

  localparam int TIMEOUT = 8;

  // ctl field order: StallF StallD StallE FlushD FlushE BubbleM mc_start mc_error
  localparam logic [7:0] C_NONE  = 8'b000_00_0_0_0;
  localparam logic [7:0] C_LU    = 8'b110_01_0_0_0;
  localparam logic [7:0] C_BR    = 8'b000_11_0_0_0;
  localparam logic [7:0] C_START = 8'b111_00_1_1_0;
  localparam logic [7:0] C_WAIT  = 8'b111_00_1_0_0;
  localparam logic [7:0] C_ERR   = 8'b111_00_1_0_1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic RegWriteM, RegWriteW, ResultSrcE, PCSrcE, mc_req_E, mc_done;
  logic [1:0] ForwardA_E, ForwardB_E, fsm_state;
  logic StallF, StallD, StallE, FlushD, FlushE, BubbleM, mc_start, mc_error;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  logic [13:0] obs;
  logic [13:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_seq_ctrl #(.MC_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .mc_req_E(mc_req_E), .mc_done(mc_done),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM),
    .mc_start(mc_start), .mc_error(mc_error),
`ifdef HAZARD_PERF_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .fsm_state_o(fsm_state)
  );

  assign obs = {ForwardA_E, ForwardB_E, StallF, StallD, StallE, FlushD, FlushE,
                BubbleM, mc_start, mc_error, fsm_state};

  function automatic logic [13:0] pk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [7:0] ctl, input logic [1:0] st);
    return {fa, fb, ctl, st};
  endfunction

  function automatic logic [1:0] fwd_model(input logic rw_m, input logic [4:0] rd_m,
                                           input logic rw_w, input logic [4:0] rd_w,
                                           input logic [4:0] rs);
    if (rw_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (rw_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0;
    RD_E = 0; RD_M = 0; RD_W = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    mc_req_E = 0; mc_done = 0;
  endtask

  // in = {mc_req_E, mc_done, PCSrcE, load_use_pattern}
  task automatic drive_row(input logic [3:0] in);
    idle_inputs();
    mc_req_E   = in[3];
    mc_done    = in[2];
    PCSrcE     = in[1];
    ResultSrcE = in[0];
    RD_E       = in[0] ? 5'd3 : 5'd0;
    Rs2_D      = in[0] ? 5'd3 : 5'd0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [13:0] e;
    idle_inputs();
    rst = 1'b0;
    #2;
    exp_q.push_back(pk(2'b00, 2'b00, C_NONE, ST_IDLE));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", obs, e); end
    mc_req_E = 1'b1;
    #1;
    checks++;
    if ({mc_start, fsm_state} !== {1'b0, ST_IDLE}) begin
      failures++; $display("FAIL reset_no_start got=%b exp=%b", {mc_start, fsm_state}, {1'b0, ST_IDLE});
    end
    step();
    checks++;
    if ({mc_start, fsm_state} !== {1'b0, ST_IDLE}) begin
      failures++; $display("FAIL reset_held got=%b exp=%b", {mc_start, fsm_state}, {1'b0, ST_IDLE});
    end
    mc_req_E = 1'b0;
    rst = 1'b1;
    step();
    exp_q.push_back(pk(2'b00, 2'b00, C_NONE, ST_IDLE));
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs, e); end
    step();
  endtask

  task automatic test_forwarding();
    logic [13:0] e;
    for (int i = 0; i < 29; i++) begin
      idle_inputs();
      case (i)
        0: begin RegWriteM = 1; RD_M = 5; RegWriteW = 1; RD_W = 5; Rs1_E = 5; end
        1: begin RegWriteM = 1; RD_M = 0; RegWriteW = 1; RD_W = 5; Rs1_E = 5; end
        2: begin RegWriteM = 0; RD_M = 7; RegWriteW = 1; RD_W = 7; Rs2_E = 7; end
        3: begin RegWriteM = 1; RD_M = 9; RegWriteW = 1; RD_W = 0; Rs1_E = 0; Rs2_E = 9; end
        4: begin RegWriteM = 0; RD_M = 4; RegWriteW = 0; RD_W = 4; Rs1_E = 4; Rs2_E = 4; end
        default: begin
          RegWriteM = 1'($urandom_range(0, 1));
          RegWriteW = 1'($urandom_range(0, 1));
          RD_M  = 5'($urandom_range(0, 3));
          RD_W  = 5'($urandom_range(0, 3));
          Rs1_E = 5'($urandom_range(0, 3));
          Rs2_E = 5'($urandom_range(0, 3));
          Rs1_D = 5'($urandom_range(0, 31));
          Rs2_D = 5'($urandom_range(0, 31));
        end
      endcase
      exp_q.push_back(pk(fwd_model(RegWriteM, RD_M, RegWriteW, RD_W, Rs1_E),
                         fwd_model(RegWriteM, RD_M, RegWriteW, RD_W, Rs2_E),
                         C_NONE, ST_IDLE));
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL forward_%0d got=%h exp=%h", i, obs, e); end
      step();
    end
  endtask

  task automatic test_load_use();
    logic [13:0] e;
    logic       rse [7] = '{1, 1, 1, 1, 0, 1, 0};
    logic [4:0] rde [7] = '{3, 3, 3, 0, 3, 3, 0};
    logic [4:0] rs1 [7] = '{7, 7, 3, 0, 3, 4, 0};
    logic [4:0] rs2 [7] = '{3, 3, 9, 0, 3, 5, 0};
    logic       br  [7] = '{0, 1, 0, 0, 0, 0, 1};
    logic [7:0] ec  [7] = '{C_LU, C_BR, C_LU, C_NONE, C_NONE, C_NONE, C_BR};
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      ResultSrcE = rse[i]; RD_E = rde[i]; Rs1_D = rs1[i]; Rs2_D = rs2[i]; PCSrcE = br[i];
      exp_q.push_back(pk(2'b00, 2'b00, ec[i], ST_IDLE));
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL load_use_%0d got=%h exp=%h", i, obs, e); end
      step();
    end
  endtask

  task automatic test_multicycle();
    logic [13:0] e;
    logic [3:0] in [9] = '{4'b1000, 4'b0000, 4'b0011, 4'b0000, 4'b0100,
                           4'b1000, 4'b0000, 4'b0100, 4'b0000};
    logic [7:0] ec [9] = '{C_START, C_WAIT, C_WAIT, C_WAIT, C_WAIT,
                           C_NONE, C_NONE, C_NONE, C_NONE};
    logic [1:0] es [9] = '{ST_IDLE, ST_WAIT, ST_WAIT, ST_WAIT, ST_WAIT,
                           ST_DONE, ST_IDLE, ST_IDLE, ST_IDLE};
    for (int i = 0; i < 9; i++) begin
      drive_row(in[i]);
      exp_q.push_back(pk(2'b00, 2'b00, ec[i], es[i]));
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL multicycle_c%0d got=%h exp=%h", i, obs, e); end
      step();
    end
  endtask

  task automatic test_done_timeout_coincide();
    logic [13:0] e;
    logic [3:0] in;
    logic [7:0] ec;
    logic [1:0] es;
    for (int i = 0; i < 11; i++) begin
      in = (i == 0) ? 4'b1000 : (i == TIMEOUT) ? 4'b0100 : 4'b0000;
      if (i == 0)             begin ec = C_START; es = ST_IDLE; end
      else if (i <= TIMEOUT)  begin ec = C_WAIT;  es = ST_WAIT; end
      else if (i == TIMEOUT+1) begin ec = C_NONE; es = ST_DONE; end
      else                    begin ec = C_NONE;  es = ST_IDLE; end
      drive_row(in);
      exp_q.push_back(pk(2'b00, 2'b00, ec, es));
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL coincide_c%0d got=%h exp=%h", i, obs, e); end
      step();
    end
  endtask

  task automatic test_timeout();
    logic [13:0] e;
    logic [3:0] in;
    logic [7:0] ec;
    logic [1:0] es;
    for (int i = 0; i < 13; i++) begin
      in = (i == 0) ? 4'b1000 : (i == 10) ? 4'b1100 : (i == 12) ? 4'b0011 : 4'b0000;
      if (i == 0)            begin ec = C_START; es = ST_IDLE; end
      else if (i <= TIMEOUT) begin ec = C_WAIT;  es = ST_WAIT; end
      else                   begin ec = C_ERR;   es = ST_ERR;  end
      drive_row(in);
      exp_q.push_back(pk(2'b00, 2'b00, ec, es));
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL timeout_c%0d got=%h exp=%h", i, obs, e); end
      step();
    end
    idle_inputs();
    rst = 1'b0;
    #2;
    exp_q.push_back(pk(2'b00, 2'b00, C_NONE, ST_IDLE));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL timeout_reset_clear got=%h exp=%h", obs, e); end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_wait();
    logic [13:0] e;
    for (int i = 0; i < 3; i++) begin
      drive_row(i == 0 ? 4'b1000 : 4'b0000);
      exp_q.push_back(pk(2'b00, 2'b00, i == 0 ? C_START : C_WAIT, i == 0 ? ST_IDLE : ST_WAIT));
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL midwait_pre_c%0d got=%h exp=%h", i, obs, e); end
      step();
    end
    rst = 1'b0;
    #2;
    exp_q.push_back(pk(2'b00, 2'b00, C_NONE, ST_IDLE));
    e = exp_q.pop_front(); checks++;
    if (obs !== e) begin failures++; $display("FAIL midwait_abort got=%h exp=%h", obs, e); end
    @(negedge clk);
    rst = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      drive_row(4'b0000);
      exp_q.push_back(pk(2'b00, 2'b00, C_NONE, ST_IDLE));
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL midwait_post_c%0d got=%h exp=%h", i, obs, e); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] e;
    logic [3:0] in [9] = '{4'b1000, 4'b0000, 4'b0100, 4'b1000, 4'b1000,
                           4'b0000, 4'b0100, 4'b0000, 4'b0000};
    logic [7:0] ec [9] = '{C_START, C_WAIT, C_WAIT, C_NONE, C_START,
                           C_WAIT, C_WAIT, C_NONE, C_NONE};
    logic [1:0] es [9] = '{ST_IDLE, ST_WAIT, ST_WAIT, ST_DONE, ST_IDLE,
                           ST_WAIT, ST_WAIT, ST_DONE, ST_IDLE};
    for (int i = 0; i < 9; i++) begin
      drive_row(in[i]);
      exp_q.push_back(pk(2'b00, 2'b00, ec[i], es[i]));
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (obs !== e) begin failures++; $display("FAIL back_to_back_c%0d got=%h exp=%h", i, obs, e); end
      step();
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    idle_inputs();
    rst = 1'b0;
    #2;
    checks++;
    if ({stall_cycles, flush_count} !== 64'd0) begin
      failures++; $display("FAIL perf_reset got=%h exp=0", {stall_cycles, flush_count});
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin drive_row(4'b0001); step(); end
    drive_row(4'b0010); step();
    drive_row(4'b0000); step();
    checks++;
    if (stall_cycles !== 32'd3) begin failures++; $display("FAIL perf_stall got=%0d exp=3", stall_cycles); end
    checks++;
    if (flush_count !== 32'd4) begin failures++; $display("FAIL perf_flush got=%0d exp=4", flush_count); end
  endtask
`endif

  initial begin
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_multicycle();
    test_done_timeout_coincide();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
